// File: rtl/sr_seq_pkg.sv
// rtl/sr_seq_pkg.sv - shared state encoding, op encoding and counter sizing
// Purpose: common definitions for the SR latch bank sequencer.
//   ST_*     : 3-bit state codes (IDLE, SETUP, PULSE, HOLD, CHECK)
//   OP_*     : requester op encoding (1 = set, 0 = clear)
//   cnt_width: width of the phase down-counter for the given phase lengths
package sr_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_PULSE = ST_PULSE,
        S_HOLD  = ST_HOLD,
        S_CHECK = ST_CHECK
    } state_t;

    // Counters are loaded with (cycles - 1), so the largest phase length m
    // needs clog2(m) bits, never fewer than one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sr_latch_bank_sequencer_if.sv
// rtl/sr_latch_bank_sequencer_if.sv - request bus and latch bus bundle
// Purpose: groups the requester handshake and the latch bank drive/readback.
//   req/op/mask : requester side inputs (mask slice i*WIDTH +: WIDTH per requester)
//   grant/done/err/busy : sequencer status back to requesters
//   s/r/en      : latch bank drive;  q : latch bank readback
//   slave  modport: the sequencer;  master modport: requesters plus latch bank
interface sr_latch_bank_sequencer_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] mask;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      s;
    logic [WIDTH-1:0]      r;
    logic                  en;
    logic [WIDTH-1:0]      q;

    modport slave (
        input  req, op, mask, q,
        output grant, done, err, busy, s, r, en
    );

    modport master (
        output req, op, mask, q,
        input  grant, done, err, busy, s, r, en
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
// Purpose: picks the first requester at or after ptr, wrapping.
//   req : request vector;  ptr : search start index
//   gnt : one-hot winner (zero when no request);  idx : winner index
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);
    // Scan from the farthest position back toward ptr so the last hit, which
    // overwrites earlier ones, is the nearest requester at or after ptr.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = ($clog2(NREQ))'(j);
            end
        end
    end
endmodule

// File: rtl/sr_latch_bank_sequencer.sv
// rtl/sr_latch_bank_sequencer.sv - setup/strobe/hold sequencer for a gated SR latch bank
// Purpose: arbitrates requesters round-robin and drives s/r/en with a safe
//   envelope, then reads q back to flag failed writes.
//   clk  : rising-edge clock;  rst_ : synchronous active-low reset
//   bus  : slave view of the request/latch bundle
// Every output is a register of the decode of the current state, so each
// output transition trails its state transition by one edge.
module sr_latch_bank_sequencer
    import sr_seq_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     clk,
    input  logic                     rst_,
    sr_latch_bank_sequencer_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [IW-1:0]    ptr, win_idx;
    logic [NREQ-1:0]  arb_gnt, gnt_r;
    logic [WIDTH-1:0] mask_r, mask_sel, qs;
    logic             op_r;
    logic             drive;

    logic [NREQ-1:0]  grant_d, done_d;
    logic [WIDTH-1:0] s_d, r_d;
    logic             en_d, err_d, busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (win_idx)
    );

    assign mask_sel = bus.mask[win_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    // An empty mask has nothing to strobe; go straight to done.
                    state_d = (|mask_sel) ? S_SETUP : S_CHECK;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) state_d = S_CHECK;
                else           cnt_d   = cnt - 1'b1;
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // s/r stay constant across SETUP, PULSE and HOLD, so they only move
        // while en is low and never on the edge where en toggles.
        drive   = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
        s_d     = (drive && op_r == OP_SET) ? mask_r : '0;
        r_d     = (drive && op_r == OP_CLR) ? mask_r : '0;
        en_d    = (state == S_PULSE);
        busy_d  = (state != S_IDLE);
        grant_d = busy_d ? gnt_r : '0;
        done_d  = (state == S_CHECK) ? gnt_r : '0;
        err_d   = (state == S_CHECK) &&
                  ((qs & mask_r) != ((op_r == OP_SET) ? mask_r : '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt_r     <= '0;
            op_r      <= OP_CLR;
            mask_r    <= '0;
            qs        <= '0;
            bus.grant <= '0;
            bus.done  <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.s     <= '0;
            bus.r     <= '0;
            bus.en    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bus.grant <= grant_d;
            bus.done  <= done_d;
            bus.err   <= err_d;
            bus.busy  <= busy_d;
            bus.s     <= s_d;
            bus.r     <= r_d;
            bus.en    <= en_d;
            if (state == S_IDLE && (|bus.req)) begin
                gnt_r  <= arb_gnt;
                op_r   <= bus.op[win_idx];
                mask_r <= mask_sel;
                ptr    <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
            // en has just been lowered by this edge; q reflects the strobe.
            if (state == S_HOLD && cnt == '0) qs <= bus.q;
        end
    end
endmodule

// File: tb/tb_sr_latch_bank_sequencer.sv
// tb/tb_sr_latch_bank_sequencer.sv - scoreboard bench for the SR latch bank sequencer
module tb_sr_latch_bank_sequencer;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_;

    sr_latch_bank_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    sr_latch_bank_sequencer #(
        .NREQ(NREQ), .WIDTH(WIDTH),
        .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural gated SR bank; stuck0 forces readback bits low.
    logic [7:0] bank   = 8'h00;
    logic [7:0] stuck0 = 8'h00;
    assign bus.q = bank & ~stuck0;
    always @(negedge clk) if (bus.en === 1'b1) bank <= (bank | bus.s) & ~bus.r;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic       err;
        logic [7:0] q;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_bank = 8'h00;
    logic       mon_on   = 1'b0;
    logic       rst_q    = 1'b0;
    logic [7:0] s_prev   = 8'h00;
    logic [7:0] r_prev   = 8'h00;
    logic       en_prev  = 1'b0;

    always @(posedge clk) rst_q <= rst_;

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_done", bus.done, 0);
        end else begin
            e = sb.pop_front();
            check("done_onehot", bus.done, 1 << e.idx);
            check("grant_with_done", bus.grant, bus.done);
            check("err", bus.err, e.err);
            check("q_readback", bus.q, e.q);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each done.
    always @(negedge clk) begin
        if (mon_on) begin
            check("s_and_r", bus.s & bus.r, 0);
            if (rst_q && ((bus.s != s_prev) || (bus.r != r_prev)))
                check("sr_change_with_en", bus.en | en_prev, 0);
            if (|bus.done) sb_pop();
        end
        s_prev  <= bus.s;
        r_prev  <= bus.r;
        en_prev <= bus.en;
    end

    // Expected result from the latch rules: set ORs, clear clears masked bits.
    task automatic push_exp(input int i, input logic o, input logic [7:0] m);
        exp_t e;
        ref_bank = o ? (ref_bank | m) : (ref_bank & ~m);
        e.idx = i;
        e.q   = ref_bank & ~stuck0;
        e.err = ((e.q & m) != (o ? m : 8'h00));
        sb.push_back(e);
    endtask

    // Issue one request from an idle sequencer and check its envelope timing.
    task automatic do_txn(input int i, input logic o, input logic [7:0] m);
        int g_at, e_at, d_at, en_cnt;
        logic [3:0] g_seen;
        logic [7:0] s_seen, r_seen;
        push_exp(i, o, m);
        bus.req[i] = 1'b1;
        bus.op[i]  = o;
        bus.mask[i*8 +: 8] = m;
        g_at = 0; e_at = 0; d_at = 0; en_cnt = 0;
        g_seen = 4'h0; s_seen = 8'h00; r_seen = 8'h00;
        for (int n = 1; n <= 20 && d_at == 0; n++) begin
            @(posedge clk); #1;
            if (g_at == 0 && bus.grant != 0) begin
                g_at = n; g_seen = bus.grant; s_seen = bus.s; r_seen = bus.r;
            end
            if (bus.en) begin
                en_cnt++;
                if (e_at == 0) e_at = n;
            end
            if (bus.done != 0) d_at = n;
        end
        bus.req[i] = 1'b0;
        check("done_seen", d_at != 0, 1);
        check("grant_at", g_at, 2);
        check("grant_val", g_seen, 1 << i);
        check("done_at", d_at, (m != 0) ? 6 : 2);
        check("en_cycles", en_cnt, (m != 0) ? 2 : 0);
        if (m != 0) check("en_first", e_at, 3);
        check("s_at_grant", s_seen, o ? m : 8'h00);
        check("r_at_grant", r_seen, o ? 8'h00 : m);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int ord[4];
        int got[$];
        int drop_at[4];
        int raise_at[4];
        int idx;
        logic [7:0] m;
        logic o;

        // Reset with every request asserted.
        rst_ = 1'b0;
        bus.req = '1; bus.op = '1; bus.mask = '1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_s", bus.s, 0);
            check("rst_r", bus.r, 0);
            check("rst_en", bus.en, 0);
            check("rst_grant", bus.grant, 0);
            check("rst_done", bus.done, 0);
            check("rst_busy", bus.busy, 0);
        end
        mon_on = 1'b1;
        bus.req = '0; bus.op = '0; bus.mask = '0;
        rst_ = 1'b1;
        @(posedge clk); #1;

        do_txn(0, 1'b1, 8'h0F);
        do_txn(2, 1'b1, 8'hFF);
        do_txn(1, 1'b0, 8'hF0);
        do_txn(3, 1'b1, 8'h00);
        stuck0 = 8'h08;
        do_txn(2, 1'b1, 8'h08);
        stuck0 = 8'h00;

        repeat (24) begin
            idx = $urandom_range(0, 3);
            o   = 1'($urandom_range(0, 1));
            m   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            stuck0 = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            do_txn(idx, o, m);
            stuck0 = 8'h00;
        end

        // Reset in the middle of the strobe; req0 stays high throughout.
        bus.req[0] = 1'b1; bus.op[0] = 1'b1; bus.mask[7:0] = 8'hA5;
        for (int n = 0; n < 20 && !bus.en; n++) begin
            @(posedge clk); #1;
        end
        check("midrst_en_seen", bus.en, 1);
        rst_ = 1'b0;
        @(posedge clk); #1;
        check("midrst_en", bus.en, 0);
        check("midrst_s", bus.s, 0);
        check("midrst_r", bus.r, 0);
        check("midrst_grant", bus.grant, 0);
        check("midrst_done", bus.done, 0);
        rst_ = 1'b1;
        do_txn(0, 1'b1, 8'hA5);

        // Fairness from a freshly reset pointer.
        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        ord = '{0, 1, 3, 0};
        for (int k = 0; k < 4; k++) begin
            bus.op[k] = 1'($urandom_range(0, 1));
            bus.mask[k*8 +: 8] = 8'($urandom_range(1, 255));
            drop_at[k] = -1; raise_at[k] = -1;
        end
        for (int k = 0; k < 4; k++) push_exp(ord[k], bus.op[ord[k]], bus.mask[ord[k]*8 +: 8]);
        bus.req = 4'b1011;
        for (int cyc = 1; cyc <= 80 && got.size() < 4; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (drop_at[k] == cyc) bus.req[k] = 1'b0;
                if (raise_at[k] == cyc) bus.req[k] = 1'b1;
            end
            if (bus.done != 0) begin
                idx = 0;
                for (int b = 0; b < 4; b++) if (bus.done[b]) idx = b;
                got.push_back(idx);
                if (got.size() == 4) begin
                    bus.req = '0;
                end else begin
                    drop_at[idx]  = cyc + 1;
                    raise_at[idx] = cyc + 2;
                end
            end
        end
        check("fair_count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) check("fair_order", got[k], ord[k]);
        repeat (10) @(posedge clk);
        #1;
        check("final_busy", bus.busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_latch_bank_sequencer.md
Name: sr_latch_bank_sequencer

Overview:
Sequences set/clear operations onto a bank of WIDTH gated SR NOR latches shared by NREQ requesters. Arbitrates round-robin, then drives s/r with a setup/strobe/hold envelope around the latch enable. The envelope never presents s=r=1 and keeps s/r stable whenever en is high. Reads the latch q back to flag failed writes. Sits between control logic and the latch bank as its only driver.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, number of latches in the bank
SETUP_CYC, 1, cycles s/r are driven with en=0 before the strobe (>=1)
PULSE_CYC, 2, cycles en is held high (>=1)
HOLD_CYC, 1, cycles s/r are held with en=0 after the strobe (>=1)

Ports:
clk  in  1  clock, rising edge
rst_  in  1  synchronous active-low reset
req  in  NREQ  request per requester; held high until its done
op  in  NREQ  per requester: 1=set, 0=clear
mask  in  NREQ*WIDTH  per-requester bit select; requester i owns slice [i*WIDTH +: WIDTH]
grant  out  NREQ  one-hot; the requester currently being served
done  out  NREQ  one-cycle pulse to the served requester at completion
err  out  1  valid with any done bit; readback mismatch
busy  out  1  high in any state other than IDLE
s  out  WIDTH  latch set bus
r  out  WIDTH  latch reset bus
en  out  1  latch enable
q  in  WIDTH  latch outputs, readback

Behaviour:
- One clock; reset is synchronous and active-low (rst_ sampled on the rising edge of clk).
- All outputs are registered.
- Reset values: s=0, r=0, en=0, grant=0, done=0, err=0, busy=0; state=IDLE; round-robin pointer=0.
- Reset does not touch latch contents.
- States: IDLE, SETUP, PULSE, HOLD, CHECK. Each of SETUP, PULSE and HOLD has a down-counter loaded on entry.
- IDLE: when any req bit is high at edge t, select the first requester at or after the pointer (wrapping). Latch its op and mask into internal registers. Set grant. Set pointer = winner+1 mod NREQ.
  - mask != 0: go to SETUP.
  - mask == 0: go to CHECK directly; no en pulse is issued.
- SETUP: s = mask & {op}, r = mask & ~{op}, en=0, for SETUP_CYC cycles.
- PULSE: s/r unchanged, en=1, for PULSE_CYC cycles.
- HOLD: s/r unchanged, en=0, for HOLD_CYC cycles. On the last HOLD edge, sample q into qs.
- CHECK: s=r=0. done[winner]=1 for one cycle. err = ((qs & mask) != (op ? mask : 0)). Next edge: IDLE, with grant=0 and done=0.
- Timing with defaults, req seen at edge t:
  - grant high from t+1 to t+6.
  - en high for the two cycles after edges t+2 and t+3.
  - done high for the cycle after edge t+5.
  - Next grant no earlier than t+7; IDLE always lasts at least 1 cycle.
- Invariants:
  - s & r == 0 always.
  - s and r change only when en=0, and never in the same cycle en changes.
  - Unmasked bits have s=r=0, so those latches hold.
- While a transaction is active, req/op/mask changes are ignored. A req that drops early still completes, and done is still issued.
- Simultaneous requests are served strictly round-robin. A requester that stays high is served again only after every other active requester.
- rst_ low in any state: the next edge forces the reset values. An interrupted operation gets no done. Its requester re-arbitrates from pointer 0.

Decomposition:
- Package sr_seq_pkg holds:
  - state encoding localparams ST_IDLE..ST_CHECK (3-bit);
  - OP_SET=1'b1, OP_CLR=1'b0;
  - the counter width, derived from the largest of SETUP_CYC, PULSE_CYC and HOLD_CYC.
- One sub-module, rr_arbiter: NREQ req in, pointer in, one-hot grant and winner index out. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: rst_=0 for 2 edges with req=all-ones -> s=r=0, en=0, grant=0, done=0, busy=0 throughout.
- Single set: req0=1, op0=1, mask0=8'h0F with a behavioural gated-SR bank on s/r/en/q, starting from q=8'h00:
  - grant=4'b0001 at t+1; s=8'h0F, r=0.
  - en high 2 cycles starting after t+2.
  - done[0] after t+5 with err=0; q=8'h0F.
- Clear with partial mask: from q=8'hFF, req1 op=0 mask=8'hF0 -> r=8'hF0, s=0, final q=8'h0F, err=0.
- Fairness: req0, req1 and req3 held high, each dropping one cycle after its done, then re-raised -> grant order 0,1,3,0.
- Zero mask and stuck bit:
  - mask=0 -> grant at t+1, done in the same cycle, en never high, err=0.
  - Bench forces q[3]=0 during a set with mask=8'h08 -> done with err=1.
- Mid-op reset: rst_=0 for one edge during PULSE -> en=0, s=r=0, grant=0 the next cycle; no done. Held req0 is re-granted after reset releases. s&r==0 checked every cycle in all tests.
